// File: rtl/mel_log_ctrl_if.sv
// Frame handshake between a mel filterbank producer and the log2 sequencer.
// The producer drives energies and a start strobe. The sequencer returns the
// log2 frame and its status pulses.
interface mel_log_ctrl_if #(
  parameter int N_CH = 13
);
  logic [N_CH-1:0][15:0] mel_in;
  logic                  mel_ready;
  logic [N_CH-1:0][15:0] log_out;
  logic                  log_ready;
  logic                  busy;
  logic                  overrun;

  modport master (
    output mel_in, mel_ready,
    input  log_out, log_ready, busy, overrun
  );

  modport slave (
    input  mel_in, mel_ready,
    output log_out, log_ready, busy, overrun
  );
endinterface

// File: rtl/mel_log_ctrl.sv
// Mel-energy log2 sequencer. A frame is captured on mel_ready. One shared log2
// datapath then walks the channels one per cycle into a working frame. The
// finished frame is published to log_out in a single cycle, with a log_ready
// pulse. Results are unsigned Q(16-FRAC_W).FRAC_W.
module mel_log_ctrl #(
  parameter int N_CH   = 13,
  parameter int FRAC_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  mel_log_ctrl_if.slave bus
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nx;
  logic [IDX_W-1:0]      idx;
  logic [N_CH-1:0][15:0] in_buf;
  logic [N_CH-1:0][15:0] work_q;
  logic                  cap_en, calc_en, done_en;
  logic                  last_ch;
  logic [15:0]           log_val;

  // Integer part is the leading-one position. The fraction is the bits below
  // the leading one, left-aligned and truncated to FRAC_W. x=0 and x=1 both
  // give zero.
  function automatic logic [15:0] log2_q(input logic [15:0] x);
    logic [3:0]  p;
    logic [15:0] norm;
    logic [15:0] r;
    p = '0;
    for (int i = 1; i < 16; i++)
      if (x[i]) p = 4'(i);
    norm = x << (4'd15 - p);
    r = '0;
    r[15:FRAC_W]  = (16-FRAC_W)'(p);
    r[FRAC_W-1:0] = norm[14 -: FRAC_W];
    return r;
  endfunction

  assign last_ch = (idx == IDX_W'(N_CH-1));
  assign log_val = log2_q(in_buf[idx]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: IDLE waits for a start, CALC walks the channels, DONE publishes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.mel_ready) state_nx = CALC;
      CALC:    if (last_ch)       state_nx = DONE;
      DONE:                       state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    cap_en  = (state == IDLE) && bus.mel_ready;
    calc_en = (state == CALC);
    done_en = (state == DONE);
  end

  // Capture buffer, channel walk and frame publish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      in_buf      <= '0;
      work_q      <= '0;
      bus.log_out <= '0;
    end else begin
      if (cap_en) begin
        in_buf <= bus.mel_in;
        idx    <= '0;
      end
      if (calc_en) begin
        work_q[idx] <= log_val;
        idx         <= last_ch ? '0 : idx + 1'b1;
      end
      // The whole frame moves at once, so a partial frame is never visible.
      if (done_en) bus.log_out <= work_q;
    end
  end

  // Status flags. busy tracks the state being entered, so it is low for
  // exactly the one IDLE cycle between back-to-back frames. A start that
  // arrives while busy is dropped and flagged on the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.log_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.log_ready <= done_en;
      bus.busy      <= (state_nx != IDLE);
      bus.overrun   <= bus.mel_ready && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_mel_log_ctrl.sv
// Directed and random bench for mel_log_ctrl. Expected frames are queued when
// a start is driven, and checked when log_ready appears.
module tb_mel_log_ctrl;
  localparam int N_CH   = 13;
  localparam int FRAC_W = 8;
  typedef logic [N_CH-1:0][15:0] frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mel_log_ctrl_if #(.N_CH(N_CH)) bus();

  mel_log_ctrl #(.N_CH(N_CH), .FRAC_W(FRAC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  frame_t exp_q[$];
  frame_t held = '0;

  // Arithmetic reference: frac = (x - 2^p) * 2^FRAC_W / 2^p, truncated
  function automatic logic [15:0] ref_log2(input logic [15:0] x);
    int p, rem, frac;
    if (x <= 16'd1) return 16'h0000;
    p = 15;
    while (x[p] == 1'b0) p--;
    rem  = int'(x) - (1 << p);
    frac = (rem << FRAC_W) >> p;
    return 16'((p << FRAC_W) + frac);
  endfunction

  function automatic frame_t ref_frame(input frame_t m);
    frame_t r;
    for (int c = 0; c < N_CH; c++) r[c] = ref_log2(m[c]);
    return r;
  endfunction

  function automatic frame_t rand_frame();
    frame_t r;
    for (int c = 0; c < N_CH; c++) begin
      case ($urandom_range(0, 7))
        0:       r[c] = 16'h0000;
        1:       r[c] = 16'h0001;
        2:       r[c] = 16'h0001 << $urandom_range(0, 15);
        3:       r[c] = 16'hFFFF;
        default: r[c] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input frame_t obs, input frame_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start at the current falling edge and drop it one cycle later
  task automatic start_frame(input frame_t m);
    bus.mel_in    = m;
    bus.mel_ready = 1'b1;
    exp_q.push_back(ref_frame(m));
    @(negedge clk);
    bus.mel_ready = 1'b0;
  endtask

  // Count falling edges since the start edge until log_ready; bounded
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.log_ready && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Scoreboard and hold check: log_out only moves on log_ready or reset
  always @(negedge clk) begin
    if (!reset_n) begin
      held = '0;
      chk("rst_log_out", bus.log_out, '0);
    end else if (bus.log_ready) begin
      chk("ready_expected", frame_t'(exp_q.size() != 0), frame_t'(1));
      if (exp_q.size() != 0) begin
        held = exp_q.pop_front();
        chk("frame", bus.log_out, held);
      end
    end else begin
      chk("hold", bus.log_out, held);
    end
  end

  initial begin
    frame_t m;
    int cyc, ov, lr, busy_lo;
    int lr_t[$];

    bus.mel_in    = '0;
    bus.mel_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",      frame_t'(bus.busy),      '0);
    chk("rst_log_ready", frame_t'(bus.log_ready), '0);
    chk("rst_overrun",   frame_t'(bus.overrun),   '0);

    // Known vectors, started on the first edge after reset release
    m = rand_frame();
    m[0] = 16'h0000; m[1] = 16'h0001; m[2] = 16'h0003;
    m[3] = 16'h0100; m[4] = 16'hFFFF; m[5] = 16'h0002;
    reset_n = 1'b1;
    start_frame(m);
    chk("busy_after_start", frame_t'(bus.busy), frame_t'(1));
    wait_done(cyc);
    chk("latency_first", frame_t'(cyc), frame_t'(15));
    chk("ch0", frame_t'(bus.log_out[0]), frame_t'(16'h0000));
    chk("ch1", frame_t'(bus.log_out[1]), frame_t'(16'h0000));
    chk("ch2", frame_t'(bus.log_out[2]), frame_t'(16'h0180));
    chk("ch3", frame_t'(bus.log_out[3]), frame_t'(16'h0800));
    chk("ch4", frame_t'(bus.log_out[4]), frame_t'(16'h0FFF));
    chk("ch5", frame_t'(bus.log_out[5]), frame_t'(16'h0100));
    chk("busy_at_done", frame_t'(bus.busy), '0);
    @(negedge clk);
    chk("ready_one_cycle", frame_t'(bus.log_ready), '0);

    // Start dropped mid-frame: one overrun, original data, one log_ready
    start_frame(rand_frame());
    ov = 0; lr = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) begin
        bus.mel_ready = 1'b1;
        bus.mel_in    = rand_frame();
      end else begin
        bus.mel_ready = 1'b0;
      end
      @(negedge clk);
      ov += int'(bus.overrun);
      lr += int'(bus.log_ready);
    end
    chk("overrun_count", frame_t'(ov), frame_t'(1));
    chk("ready_count",   frame_t'(lr), frame_t'(1));

    // mel_ready held for 40 cycles: three back-to-back frames
    m = rand_frame();
    bus.mel_in    = m;
    bus.mel_ready = 1'b1;
    repeat (3) exp_q.push_back(ref_frame(m));
    busy_lo = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 40) bus.mel_ready = 1'b0;
      @(negedge clk);
      if (bus.log_ready) lr_t.push_back(i);
      if (i < 44 && !bus.busy) busy_lo++;
    end
    chk("held_frames", frame_t'(lr_t.size()), frame_t'(3));
    if (lr_t.size() == 3) begin
      chk("held_period1", frame_t'(lr_t[1] - lr_t[0]), frame_t'(15));
      chk("held_period2", frame_t'(lr_t[2] - lr_t[1]), frame_t'(15));
    end
    chk("held_busy_low", frame_t'(busy_lo), frame_t'(2));

    // Reset at the 7th CALC edge: frame discarded, outputs clear at once
    start_frame(rand_frame());
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_log_out", bus.log_out, '0);
    chk("mid_rst_busy",    frame_t'(bus.busy), '0);
    chk("mid_rst_ready",   frame_t'(bus.log_ready), '0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_ready_after_rst", frame_t'(exp_q.size()), '0);
    start_frame(rand_frame());
    wait_done(cyc);
    chk("latency_after_rst", frame_t'(cyc), frame_t'(15));
    @(negedge clk);

    // Inputs churn after the start edge; only captured values count
    start_frame(rand_frame());
    cyc = 1;
    while (!bus.log_ready && cyc < 60) begin
      bus.mel_in = rand_frame();
      @(negedge clk);
      cyc++;
    end
    chk("latency_churn", frame_t'(cyc), frame_t'(15));
    @(negedge clk);

    // Random frames with random idle gaps
    for (int f = 0; f < 1000; f++) begin
      start_frame(rand_frame());
      wait_done(cyc);
      chk("latency_rand", frame_t'(cyc), frame_t'(15));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", frame_t'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
